decoder_n_scan: RTL



---
 rtl/decoder_n_scan_if.sv | 29 ++
 rtl/decoder_n_scan.sv | 81 ++++++++
 2 files changed

// File: rtl/decoder_n_scan_if.sv
// Bus bundle for decoder_n_scan.
//   master : drives en, mode, sel; observes out, idx, wrap (control logic side)
//   slave  : the decoder itself
//   en   - block enable (low forces all lines inactive)
//   mode - 0 = direct decode of sel, 1 = auto-scan
//   sel  - line select used in direct mode
//   out  - registered one-hot (or one-cold) line drive, 2^SEL_W wide
//   idx  - registered index of the active line
//   wrap - one-cycle pulse when the scan wraps from the last line to 0
interface decoder_n_scan_if #(
    parameter int SEL_W = 3
);
    logic                    en;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [(1<<SEL_W)-1:0]   out;
    logic [SEL_W-1:0]        idx;
    logic                    wrap;

    modport master (
        output en, mode, sel,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel,
        output out, idx, wrap
    );
endinterface

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N line decoder with an auto-scan mode.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - decoder_n_scan_if slave port (en, mode, sel in; out, idx, wrap out)
// Direct mode drives the line picked by sel one clock later. Scan mode walks
// the active line through every output, holding each for DWELL clocks, and
// pulses wrap when the index rolls over from the last line back to 0.
module decoder_n_scan #(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    decoder_n_scan_if.slave bus
);
    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);
    localparam logic [N-1:0]     INACTIVE = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] idx_nxt;

    // Polarity is applied only here, at the value loaded into the output register.
    function automatic logic [N-1:0] line_drive(input logic [SEL_W-1:0] line);
        logic [N-1:0] oh;
        oh       = '0;
        oh[line] = 1'b1;
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    // Natural wrap of the SEL_W-bit sum gives the modulo-2^SEL_W advance.
    assign idx_nxt = bus.idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.out  <= INACTIVE;
            bus.idx  <= '0;
            bus.wrap <= 1'b0;
        end else if (!bus.en) begin
            // idx is deliberately held so the last line stays observable.
            state    <= IDLE;
            cnt      <= '0;
            bus.out  <= INACTIVE;
            bus.wrap <= 1'b0;
        end else if (!bus.mode) begin
            state    <= DIRECT;
            cnt      <= '0;
            bus.out  <= line_drive(bus.sel);
            bus.idx  <= bus.sel;
            bus.wrap <= 1'b0;
        end else if (state != SCAN) begin
            // Every entry into scan restarts from line 0 with a fresh dwell.
            state    <= SCAN;
            cnt      <= '0;
            bus.out  <= line_drive('0);
            bus.idx  <= '0;
            bus.wrap <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            bus.out  <= line_drive(idx_nxt);
            bus.idx  <= idx_nxt;
            bus.wrap <= (bus.idx == IDX_LAST);
        end else begin
            cnt      <= cnt + CNT_W'(1);
            bus.wrap <= 1'b0;
        end
    end
endmodule
